// File: rtl/can_tx_queue_if.sv
// ---------------------------------------------------------------------------
// can_tx_queue_if
// Host-side write bus of the CAN transmit queue.
//   wr_valid  : host presents a frame
//   wr_ready  : queue can accept (driven by the queue)
//   wr_ide    : extended-ID flag
//   wr_id_std : 11-bit standard identifier
//   wr_id_ext : 29-bit extended identifier
//   wr_rtr    : remote frame flag
//   wr_dlc    : data length code, stored unmodified
//   wr_data   : payload, byte n in [8n+7:8n]
// Modports: master = host, slave = queue.
// ---------------------------------------------------------------------------
interface can_tx_queue_if;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_ide;
  logic [10:0] wr_id_std;
  logic [28:0] wr_id_ext;
  logic        wr_rtr;
  logic [3:0]  wr_dlc;
  logic [63:0] wr_data;

  modport master (
    output wr_valid, wr_ide, wr_id_std, wr_id_ext, wr_rtr, wr_dlc, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_ide, wr_id_std, wr_id_ext, wr_rtr, wr_dlc, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/can_tx_queue.sv
// ---------------------------------------------------------------------------
// can_tx_queue
// Transmit frame queue in front of the CAN controller. Buffers up to DEPTH
// frames in a circular buffer, presents the oldest on registered frame-field
// outputs, pulses start_tx when the bus is idle, retires the frame on tx_done
// and retries it on tx_abort until MAX_RETRY consecutive aborts drop it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr                    : host write bus (can_tx_queue_if.slave)
//   bus_idle              : controller reports bus free
//   tx_done / tx_abort    : outcome of the current attempt
//   start_tx              : one-cycle transmit request
//   ide..tx_data_7        : head-entry frame fields (stable while BUSY)
//   count, empty, full    : occupancy
//   sent, dropped         : one-cycle retire pulses
//   retry_cnt             : aborts accumulated by the current head
// ---------------------------------------------------------------------------
module can_tx_queue #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  can_tx_queue_if.slave          wr,
  input  logic                   bus_idle,
  input  logic                   tx_done,
  input  logic                   tx_abort,
  output logic                   start_tx,
  output logic                   ide,
  output logic [10:0]            id_std,
  output logic [28:0]            id_ext,
  output logic                   rtr,
  output logic [3:0]             dlc,
  output logic [7:0]             tx_data_0,
  output logic [7:0]             tx_data_1,
  output logic [7:0]             tx_data_2,
  output logic [7:0]             tx_data_3,
  output logic [7:0]             tx_data_4,
  output logic [7:0]             tx_data_5,
  output logic [7:0]             tx_data_6,
  output logic [7:0]             tx_data_7,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   sent,
  output logic                   dropped,
  output logic [7:0]             retry_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 110;  // ide + id_std + id_ext + rtr + dlc + data

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    retry_q, retry_d;
  logic [EW-1:0] frame_q, frame_d;
  logic          start_q, start_d;
  logic          sent_q, sent_d;
  logic          dropped_q, dropped_d;
  logic          full_w, push, pop;

  assign wr_entry = {wr.wr_ide, wr.wr_id_std, wr.wr_id_ext, wr.wr_rtr,
                     wr.wr_dlc, wr.wr_data};

  // Acceptance looks only at the registered count: a full queue refuses a
  // write even when the head is popped on the same edge.
  assign full_w      = (count_q == (PW+1)'(DEPTH));
  assign push        = wr.wr_valid && !full_w;
  assign wr.wr_ready = !full_w;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    retry_d   = retry_q;
    frame_d   = frame_q;
    start_d   = 1'b0;
    sent_d    = 1'b0;
    dropped_d = 1'b0;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0 && bus_idle) begin
          state_d = BUSY;
          frame_d = mem_q[rd_ptr_q];
          start_d = 1'b1;
        end
      end
      BUSY: begin
        // tx_done has priority over a simultaneous tx_abort.
        if (tx_done) begin
          state_d = GAP;
          pop     = 1'b1;
          sent_d  = 1'b1;
          retry_d = '0;
        end else if (tx_abort) begin
          state_d = GAP;
          if ({1'b0, retry_q} + 9'd1 == 9'(MAX_RETRY)) begin
            pop       = 1'b1;
            dropped_d = 1'b1;
            retry_d   = '0;
          end else begin
            retry_d = retry_q + 8'd1;
          end
        end
      end
      // One dead cycle so start_tx can never fire back-to-back.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      retry_q   <= '0;
      frame_q   <= '0;
      start_q   <= 1'b0;
      sent_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      retry_q   <= retry_d;
      frame_q   <= frame_d;
      start_q   <= start_d;
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
    end
  end

  // Frame storage carries no reset; stale entries are never read because
  // the read side is gated by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign {ide, id_std, id_ext, rtr, dlc,
          tx_data_7, tx_data_6, tx_data_5, tx_data_4,
          tx_data_3, tx_data_2, tx_data_1, tx_data_0} = frame_q;

  assign start_tx  = start_q;
  assign sent      = sent_q;
  assign dropped   = dropped_q;
  assign retry_cnt = retry_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = full_w;

endmodule

// File: tb/tb_can_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_can_tx_queue
// Table-driven bench for can_tx_queue plus hand-written sequences for
// fill/drain ordering, retry-drop and reset during a transmission.
// ---------------------------------------------------------------------------
module tb_can_tx_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_idle, tx_done, tx_abort;
  logic        start_tx, ide, rtr, empty, full, sent, dropped;
  logic [10:0] id_std;
  logic [28:0] id_ext;
  logic [3:0]  dlc;
  logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7, retry_cnt;
  logic [2:0]  count;
  logic [109:0] out_frm;

  int n_run  = 0;
  int n_fail = 0;

  can_tx_queue_if wr_if();

  can_tx_queue #(.DEPTH(4), .MAX_RETRY(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr_if.slave),
    .bus_idle(bus_idle), .tx_done(tx_done), .tx_abort(tx_abort),
    .start_tx(start_tx), .ide(ide), .id_std(id_std), .id_ext(id_ext),
    .rtr(rtr), .dlc(dlc),
    .tx_data_0(d0), .tx_data_1(d1), .tx_data_2(d2), .tx_data_3(d3),
    .tx_data_4(d4), .tx_data_5(d5), .tx_data_6(d6), .tx_data_7(d7),
    .count(count), .empty(empty), .full(full), .sent(sent),
    .dropped(dropped), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  assign out_frm = {ide, id_std, id_ext, rtr, dlc, d7, d6, d5, d4, d3, d2, d1, d0};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic         wv, dn, ab;
    logic [109:0] frm;
    logic         es, esent, edrop;
    int           ecnt, eretry;
    logic         cf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [109:0] mkf(logic i, logic [10:0] s, logic [28:0] e,
                                       logic r, logic [3:0] l, logic [63:0] d);
    return {i, s, e, r, l, d};
  endfunction

  function automatic vec_t mk(logic wv, logic dn, logic ab, logic [109:0] f,
                              logic es, logic esent, logic edrop,
                              int cnt, int rt, logic cf);
    vec_t v;
    v.wv = wv; v.dn = dn; v.ab = ab; v.frm = f;
    v.es = es; v.esent = esent; v.edrop = edrop;
    v.ecnt = cnt; v.eretry = rt; v.cf = cf;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(logic [109:0] f);
    wr_if.wr_ide    = f[109];
    wr_if.wr_id_std = f[108:98];
    wr_if.wr_id_ext = f[97:69];
    wr_if.wr_rtr    = f[68];
    wr_if.wr_dlc    = f[67:64];
    wr_if.wr_data   = f[63:0];
  endtask

  task automatic push(logic [109:0] f);
    set_frame(f);
    wr_if.wr_valid = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (start_tx === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_start"},   128'(start_tx), 128'(0));
    chk({tag, "_sent"},    128'(sent), 128'(0));
    chk({tag, "_dropped"}, 128'(dropped), 128'(0));
    chk({tag, "_count"},   128'(count), 128'(0));
    chk({tag, "_retry"},   128'(retry_cnt), 128'(0));
    chk({tag, "_empty"},   128'(empty), 128'(1));
    chk({tag, "_full"},    128'(full), 128'(0));
    chk({tag, "_wr_ready"},128'(wr_if.wr_ready), 128'(1));
    chk({tag, "_frame"},   128'(out_frm), 128'(0));
  endtask

  logic [109:0] fa, fb, fc, fbad, fg, fh, fp, fq_, fn;
  logic [109:0] fq [5];
  bit ok;
  int qn;

  initial begin
    rst_n = 1'b0;
    bus_idle = 1'b0; tx_done = 1'b0; tx_abort = 1'b0;
    wr_if.wr_valid = 1'b0;
    set_frame('0);

    fa   = mkf(1'b0, 11'h5F7, 29'h0, 1'b0, 4'd4, 64'h0000_0000_4433_2288);
    fb   = mkf(1'b1, 11'h000, 29'h1ABC_DE12, 1'b1, 4'd0, 64'h0);
    fc   = mkf(1'b0, 11'h123, 29'h0, 1'b0, 4'hF, 64'h0123_4567_89AB_CDEF);
    fbad = mkf(1'b1, 11'h7FF, 29'h1FFF_FFFF, 1'b1, 4'hE, 64'hDEAD_BEEF_DEAD_BEEF);
    fg   = mkf(1'b0, 11'h0AA, 29'h0, 1'b0, 4'd2, 64'h0000_0000_0000_BEEF);
    fh   = mkf(1'b1, 11'h000, 29'h0555_5555, 1'b0, 4'd8, 64'hFEDC_BA98_7654_3210);
    fp   = mkf(1'b0, 11'h011, 29'h0, 1'b0, 4'd1, 64'h11);
    fq_  = mkf(1'b0, 11'h022, 29'h0, 1'b0, 4'd1, 64'h22);
    fn   = mkf(1'b0, 11'h333, 29'h0, 1'b1, 4'd3, 64'h0033_3333);
    for (int k = 0; k < 5; k++)
      fq[k] = mkf(1'(k % 2), 11'(11'h100 + k), 29'(29'h0100_0000 + k * 3),
                  1'(k == 2), 4'(k + 1), {8{8'(8'h11 * (k + 1))}});

    // Reset state
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Vector table: bus_idle held at 1
    tbl.push_back(mk(1,0,0, fa, 0,0,0, 1,0, 0));   // push A
    tbl.push_back(mk(0,0,0, fa, 1,0,0, 1,0, 1));   // start, fields valid
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0,0,0, fa, 0,0,0, 1,0, 1)); // BUSY, fields held
    tbl.push_back(mk(0,1,0, fa, 0,1,0, 0,0, 0));   // done
    tbl.push_back(mk(0,0,0, fa, 0,0,0, 0,0, 0));   // GAP->IDLE
    tbl.push_back(mk(0,1,0, fa, 0,0,0, 0,0, 0));   // done in IDLE ignored
    tbl.push_back(mk(1,0,0, fb, 0,0,0, 1,0, 0));   // push B
    tbl.push_back(mk(0,0,0, fb, 1,0,0, 1,0, 1));
    for (int a = 1; a <= 3; a++) begin
      tbl.push_back(mk(0,0,1, fb, 0,0,0, 1,a, 0)); // abort
      tbl.push_back(mk(0,0,0, fb, 0,0,0, 1,a, 0)); // GAP->IDLE
      tbl.push_back(mk(0,0,0, fb, 1,0,0, 1,a, 1)); // retry start, same fields
    end
    tbl.push_back(mk(0,1,0, fb, 0,1,0, 0,0, 0));   // done clears retry
    tbl.push_back(mk(0,0,0, fb, 0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, fc, 0,0,0, 1,0, 0));   // push C, dlc=15
    tbl.push_back(mk(0,0,0, fc, 1,0,0, 1,0, 1));
    tbl.push_back(mk(0,1,1, fc, 0,1,0, 0,0, 0));   // done+abort -> done
    tbl.push_back(mk(0,0,0, fc, 0,0,0, 0,0, 0));

    bus_idle = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      wr_if.wr_valid = tbl[i].wv;
      set_frame(tbl[i].frm);
      tx_done  = tbl[i].dn;
      tx_abort = tbl[i].ab;
      step();
      chk($sformatf("v%0d_start", i),   128'(start_tx),  128'(tbl[i].es));
      chk($sformatf("v%0d_sent", i),    128'(sent),      128'(tbl[i].esent));
      chk($sformatf("v%0d_dropped", i), 128'(dropped),   128'(tbl[i].edrop));
      chk($sformatf("v%0d_count", i),   128'(count),     128'(tbl[i].ecnt));
      chk($sformatf("v%0d_retry", i),   128'(retry_cnt), 128'(tbl[i].eretry));
      if (tbl[i].cf) chk($sformatf("v%0d_frame", i), 128'(out_frm), 128'(tbl[i].frm));
    end
    wr_if.wr_valid = 1'b0; tx_done = 1'b0; tx_abort = 1'b0;

    // Fill to full, refuse a fifth write, then drain in order with wrap
    bus_idle = 1'b0;
    for (int k = 0; k < 4; k++) push(fq[k]);
    chk("fill_count", 128'(count), 128'(4));
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_wr_ready", 128'(wr_if.wr_ready), 128'(0));
    chk("fill_empty", 128'(empty), 128'(0));
    push(fbad);
    chk("overflow_count", 128'(count), 128'(4));
    bus_idle = 1'b1;
    qn = 4;
    for (int k = 0; k < 5; k++) begin
      wait_start(ok);
      chk($sformatf("drain%0d_start_seen", k), 128'(ok), 128'(1));
      chk($sformatf("drain%0d_frame", k), 128'(out_frm), 128'(fq[k]));
      tx_done = 1'b1;
      if (k == 1) begin
        set_frame(fq[4]);
        wr_if.wr_valid = 1'b1;
      end
      step();
      tx_done = 1'b0;
      wr_if.wr_valid = 1'b0;
      qn = qn - 1 + ((k == 1) ? 1 : 0);
      chk($sformatf("drain%0d_sent", k), 128'(sent), 128'(1));
      chk($sformatf("drain%0d_count", k), 128'(count), 128'(qn));
    end
    chk("drain_empty", 128'(empty), 128'(1));

    // Eight consecutive aborts drop the head; next frame starts fresh
    bus_idle = 1'b0;
    push(fg);
    push(fh);
    bus_idle = 1'b1;
    for (int a = 0; a < 8; a++) begin
      wait_start(ok);
      chk($sformatf("abort%0d_start_seen", a), 128'(ok), 128'(1));
      chk($sformatf("abort%0d_frame", a), 128'(out_frm), 128'(fg));
      chk($sformatf("abort%0d_retry_pre", a), 128'(retry_cnt), 128'(a));
      tx_abort = 1'b1;
      step();
      tx_abort = 1'b0;
      chk($sformatf("abort%0d_dropped", a), 128'(dropped), 128'(a == 7));
      chk($sformatf("abort%0d_sent", a), 128'(sent), 128'(0));
      chk($sformatf("abort%0d_retry", a), 128'(retry_cnt), 128'((a == 7) ? 0 : a + 1));
      chk($sformatf("abort%0d_count", a), 128'(count), 128'((a == 7) ? 1 : 2));
    end
    wait_start(ok);
    chk("next_start_seen", 128'(ok), 128'(1));
    chk("next_frame", 128'(out_frm), 128'(fh));
    chk("next_retry", 128'(retry_cnt), 128'(0));
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("next_sent", 128'(sent), 128'(1));
    chk("next_count", 128'(count), 128'(0));

    // Reset while BUSY with two frames queued
    bus_idle = 1'b0;
    push(fp);
    push(fq_);
    bus_idle = 1'b1;
    wait_start(ok);
    chk("rb_start_seen", 128'(ok), 128'(1));
    chk("rb_count_pre", 128'(count), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rb");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst%0d_start", i), 128'(start_tx), 128'(0));
      chk($sformatf("post_rst%0d_pulses", i), 128'({sent, dropped}), 128'(0));
      chk($sformatf("post_rst%0d_count", i), 128'(count), 128'(0));
    end
    push(fn);
    wait_start(ok);
    chk("post_rst_new_start", 128'(ok), 128'(1));
    chk("post_rst_new_frame", 128'(out_frm), 128'(fn));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
